// File: rtl/bk_arith_pkg.sv
// Shared Brent-Kung arithmetic types and helpers for the add/subtract pipeline and its benches.
// Group generate/propagate pair, prefix combine operator and operand (de)interleaving.
package bk_arith_pkg;

    localparam int WIDTH_DEFAULT = 12;
    localparam int STAGES        = 3;

    // Tree depth; widths of 1 or 2 still get one level so the sweep loops stay well formed.
    function automatic int levels(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int LEVELS = levels(WIDTH_DEFAULT);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // hi covers the more significant span, lo the adjacent less significant span.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic logic [2*WIDTH_DEFAULT-1:0] interleave(
        input logic [WIDTH_DEFAULT-1:0] a,
        input logic [WIDTH_DEFAULT-1:0] b
    );
        logic [2*WIDTH_DEFAULT-1:0] r;
        for (int i = 0; i < WIDTH_DEFAULT; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic void deinterleave(
        input  logic [2*WIDTH_DEFAULT-1:0] ops,
        output logic [WIDTH_DEFAULT-1:0]   a,
        output logic [WIDTH_DEFAULT-1:0]   b
    );
        for (int i = 0; i < WIDTH_DEFAULT; i++) begin
            a[i] = ops[2*i];
            b[i] = ops[2*i+1];
        end
    endfunction

endpackage

// File: rtl/bk_pipe_ctrl.sv
// Stage-valid tracking for the three-stage add/subtract pipeline with a single global stall.
// cap[k] enables data capture into stage k+1 on the coming edge.
module bk_pipe_ctrl
    import bk_arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [STAGES-1:0] cap
);

    logic [STAGES-1:0] valid_q;
    logic              advance;

    // Whole pipe moves together: it may move whenever the output stage is empty or being taken.
    assign advance   = ~valid_q[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign cap       = {STAGES{advance}} & {valid_q[STAGES-2:0], in_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= {valid_q[STAGES-2:0], in_valid};
        end
    end

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage Brent-Kung add/subtract: S1 captures g/p, S2 holds the up-sweep tree,
// S3 holds the result after the down-sweep fills in every prefix carry.
module brent_kung_sub_pipe
    import bk_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_ops,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_res,
    output logic               out_cout,
    output logic               out_borrow,
    output logic               out_ovf
);

    localparam int L = levels(WIDTH);
    localparam int N = 1 << L;

    logic [STAGES-1:0] cap;

    bk_pipe_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .cap       (cap)
    );

    gp_t              gp_s1_d [N];
    gp_t              gp_s1_q [N];
    logic             sub_s1_q;
    gp_t              node_s2_q [N];
    logic [WIDTH-1:0] p_s2_q;
    logic             sub_s2_q;
    gp_t              fin [N];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    genvar gl, gi;

    // Carry-in folds into bit 0's generate so the tree yields carries that already include it.
    generate
        for (gi = 0; gi < N; gi++) begin : g_s1
            if (gi < WIDTH) begin : g_bit
                logic a_bit, bb_bit, g_bit, p_bit;
                assign a_bit  = in_ops[2*gi];
                assign bb_bit = in_ops[2*gi+1] ^ in_sub;
                assign p_bit  = a_bit ^ bb_bit;
                if (gi == 0) begin : g_cin
                    assign g_bit = (a_bit & bb_bit) | (p_bit & in_sub);
                end else begin : g_plain
                    assign g_bit = a_bit & bb_bit;
                end
                assign gp_s1_d[gi] = '{g: g_bit, p: p_bit};
            end else begin : g_pad
                assign gp_s1_d[gi] = '{g: 1'b0, p: 1'b0};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (cap[0]) begin
            gp_s1_q  <= gp_s1_d;
            sub_s1_q <= in_sub;
        end
    end

    generate
        for (gl = 0; gl <= L; gl++) begin : g_up
            gp_t node [N];
            for (gi = 0; gi < N; gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    assign node[gi] = gp_s1_q[gi];
                end else if (((gi + 1) % (1 << gl)) == 0) begin : g_merge
                    assign node[gi] = gp_combine(g_up[gl-1].node[gi], g_up[gl-1].node[gi-(1<<(gl-1))]);
                end else begin : g_pass
                    assign node[gi] = g_up[gl-1].node[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (cap[1]) begin
            node_s2_q <= g_up[L].node;
            sub_s2_q  <= sub_s1_q;
            for (int i = 0; i < WIDTH; i++) begin
                p_s2_q[i] <= gp_s1_q[i].p;
            end
        end
    end

    // Down-sweep level gl handles span 2^(L-gl-1): odd-half nodes pick up the prefix to their left.
    generate
        for (gl = 0; gl < L; gl++) begin : g_dn
            gp_t node [N];
            for (gi = 0; gi < N; gi++) begin : g_node
                if (gl == 0) begin : g_root
                    assign node[gi] = node_s2_q[gi];
                end else if ((((gi + 1) % (1 << (L - gl))) == (1 << (L - gl - 1))) &&
                             (gi >= (1 << (L - gl)))) begin : g_merge
                    assign node[gi] = gp_combine(g_dn[gl-1].node[gi], g_dn[gl-1].node[gi-(1<<(L-gl-1))]);
                end else begin : g_pass
                    assign node[gi] = g_dn[gl-1].node[gi];
                end
            end
        end
    endgenerate

    assign fin = g_dn[L-1].node;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sum
            if (gi == 0) begin : g_c0
                assign carry[gi] = sub_s2_q;
            end else begin : g_ci
                assign carry[gi] = fin[gi-1].g;
            end
            assign sum_d[gi] = p_s2_q[gi] ^ carry[gi];
        end
    endgenerate

    assign cout_d = fin[WIDTH-1].g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res    <= '0;
            out_cout   <= 1'b0;
            out_borrow <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (cap[2]) begin
            out_res    <= sum_d;
            out_cout   <= cout_d;
            out_borrow <= sub_s2_q & ~cout_d;
            out_ovf    <= carry[WIDTH-1] ^ cout_d;
        end
    end

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Scoreboard bench for brent_kung_sub_pipe: expected results are queued on input handshake
// and a negedge monitor pops and compares on every output handshake.
module tb_brent_kung_sub_pipe;
    import bk_arith_pkg::*;

    typedef struct packed {
        logic [11:0] res;
        logic        cout;
        logic        borrow;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic        s;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_ops;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_res;
    logic        out_cout;
    logic        out_borrow;
    logic        out_ovf;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    int   n_push = 0;
    int   rdy_mode = 0;
    logic hold_vld = 1'b0;
    exp_t hold_val;

    brent_kung_sub_pipe #(.WIDTH(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ops     (in_ops),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_cout   (out_cout),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: output handshake pops the scoreboard; a stalled output must stay put.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = '{res: out_res, cout: out_cout, borrow: out_borrow, ovf: out_ovf};
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                n_cmp++;
                if (!out_valid || got != hold_val) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%0b res=%03h flags=%03b required valid=1 res=%03h flags=%03b",
                             out_valid, got.res, {got.cout, got.borrow, got.ovf},
                             hold_val.res, {hold_val.cout, hold_val.borrow, hold_val.ovf});
                end
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got res=%03h with no result outstanding, required none", got.res);
                end else begin
                    e = sb.pop_front();
                    if (got != e) begin
                        n_fail++;
                        $display("FAIL result #%0d: got res=%03h cout=%0b borrow=%0b ovf=%0b required res=%03h cout=%0b borrow=%0b ovf=%0b",
                                 n_xfer, got.res, got.cout, got.borrow, got.ovf, e.res, e.cout, e.borrow, e.ovf);
                    end else begin
                        $display("xfer %0d: res=%03h cout=%0b borrow=%0b ovf=%0b ok", n_xfer, got.res, got.cout, got.borrow, got.ovf);
                    end
                end
            end
            hold_vld = out_valid && !out_ready;
            hold_val = got;
        end
    end

    function automatic exp_t model(input logic [11:0] a, input logic [11:0] b, input logic s);
        logic [11:0] bb;
        logic [12:0] full;
        exp_t        r;
        bb       = b ^ {12{s}};
        full     = {1'b0, a} + {1'b0, bb} + {12'd0, s};
        r.res    = full[11:0];
        r.cout   = full[12];
        r.borrow = s & ~full[12];
        r.ovf    = (a[11] == bb[11]) && (full[11] != a[11]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [11:0] a, input logic [11:0] b, input logic s,
                                input logic [11:0] res, input logic c, input logic bo, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.s = s;
        v.e = '{res: res, cout: c, borrow: bo, ovf: o};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the beat's accepting edge.
    task automatic send(input vec_t v);
        int guard;
        guard    = 0;
        in_ops   = interleave(v.a, v.b);
        in_sub   = v.s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, required 1", guard);
        end else begin
            sb.push_back(v.e);
            n_push++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Beat accepted at edge E: out_valid absent after E and E+1, present after E+2.
    task automatic lat_check(input string name, input vec_t v);
        logic [2:0] seen;
        send(v);
        @(negedge clk); seen[2] = out_valid;
        @(negedge clk); seen[1] = out_valid;
        @(negedge clk); seen[0] = out_valid;
        chk(name, 32'(seen), 32'(3'b001));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d results outstanding, required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        dir [6];
        vec_t        bp  [5];
        vec_t        v;
        logic [23:0] ops;
        logic [11:0] ra, rb;
        int          base;

        dir[0] = mk(12'h005, 12'h003, 1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
        dir[1] = mk(12'h000, 12'h001, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0);
        dir[2] = mk(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        dir[3] = mk(12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b0, 1'b1);
        dir[4] = mk(12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b0, 1'b1);
        dir[5] = mk(12'h123, 12'h123, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
        bp[0]  = mk(12'h100, 12'h023, 1'b0, 12'h123, 1'b0, 1'b0, 1'b0);
        bp[1]  = mk(12'h456, 12'h111, 1'b0, 12'h567, 1'b0, 1'b0, 1'b0);
        bp[2]  = mk(12'h800, 12'h800, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
        bp[3]  = mk(12'h400, 12'h400, 1'b0, 12'h800, 1'b0, 1'b0, 1'b1);
        bp[4]  = mk(12'h0AB, 12'h0BA, 1'b1, 12'hFF1, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_ops = '0; in_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res", 32'(out_res), 32'd0);
        chk("rst_flags", 32'({out_cout, out_borrow, out_ovf}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        lat_check("latency_sub_5_3", dir[0]);
        for (int i = 1; i < 6; i++) send(dir[i]);
        drain("drain_directed");

        // Backpressure: three beats fill the stalled pipe, then release and stream two more.
        @(negedge clk); rdy_mode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(bp[i]);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        repeat (4) @(negedge clk);
        base = n_xfer;
        rdy_mode = 0;
        @(posedge clk); #1;
        send(bp[3]);
        send(bp[4]);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_five_in_five_cycles", 32'(n_xfer - base), 32'd5);
        drain("drain_backpressure");

        // Reset with three beats in flight: they vanish, a fresh beat comes through clean.
        @(negedge clk); rdy_mode = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(bp[i]);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_res", 32'(out_res), 32'd0);
        n_push -= sb.size();
        sb.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        lat_check("postrst_latency", mk(12'h010, 12'h020, 1'b1, 12'hFF0, 1'b0, 1'b1, 1'b0));
        drain("drain_reset");

        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            ops = 24'($urandom);
            v.s = 1'($urandom_range(0, 1));
            deinterleave(ops, ra, rb);
            v.a = ra;
            v.b = rb;
            v.e = model(ra, rb, v.s);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(v);
        end
        rdy_mode = 0;
        drain("drain_random");
        chk("xfer_count", 32'(n_xfer), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
